// File: rtl/deep_ff_ctrl_pipe.sv
// deep_ff_ctrl_pipe: 2-stage valid/ready op pipeline (mode/in1/in2 in; data_out/flag_out/op_count out) with accumulator and saturating add
module deep_ff_ctrl_pipe #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             dffcl_clk,
  input  logic             dffcl_rst_n,
  input  logic             dffcl_in_valid,
  output logic             dffcl_in_ready,
  input  logic [3:0]       dffcl_ctrl_mode,
  input  logic [WIDTH-1:0] dffcl_data_in1,
  input  logic [WIDTH-1:0] dffcl_data_in2,
  output logic             dffcl_out_valid,
  input  logic             dffcl_out_ready,
  output logic [WIDTH-1:0] dffcl_data_out,
  output logic             dffcl_flag_out,
  output logic [CNT_W-1:0] dffcl_op_count
);
  logic             s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic [3:0]       s1_mode_q, s1_mode_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic [WIDTH-1:0] data_q, data_d, acc_q, acc_d;
  logic             flag_q, flag_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s2_adv, in_fire, res_f;
  logic [WIDTH:0]   add_s, acc_s, inc_s;
  logic [WIDTH-1:0] a, b, sel, res;
  always_comb begin
    a        = s1_a_q;
    b        = s1_b_q;
    s2_adv   = s1_valid_q && (!s2_valid_q || dffcl_out_ready);
    in_fire  = dffcl_in_valid && (!s1_valid_q || s2_adv);
    add_s    = {1'b0, a} + {1'b0, b};
    acc_s    = {1'b0, acc_q} + {1'b0, a};
    inc_s    = {1'b0, a} + (WIDTH+1)'(1);
    sel      = a[WIDTH-1] ? inc_s[WIDTH-1:0] :
               a[WIDTH-2] ? (b[0] ? a << 1 : a >> 1) :
               a[WIDTH-3] ? ~b : b;
    res      = s1_mode_q[2] ? a : b;
    res_f    = 1'b0;
    case (s1_mode_q)
      4'd0: begin res = add_s[WIDTH-1:0]; res_f = add_s[WIDTH]; end
      4'd1: begin res = (a < b) ? b - a : a - b; res_f = a < b; end
      4'd2: begin res = sel; res_f = a[WIDTH-1] & inc_s[WIDTH]; end
      4'd3: begin res = acc_s[WIDTH-1:0]; res_f = acc_s[WIDTH]; end
      4'd4: res = a;
      4'd5: begin res = add_s[WIDTH] ? '1 : add_s[WIDTH-1:0]; res_f = add_s[WIDTH]; end
      default: ;
    endcase
    s1_valid_d = in_fire ? 1'b1 : (s2_adv ? 1'b0 : s1_valid_q);
    s1_mode_d  = in_fire ? dffcl_ctrl_mode : s1_mode_q;
    s1_a_d     = in_fire ? dffcl_data_in1 : s1_a_q;
    s1_b_d     = in_fire ? dffcl_data_in2 : s1_b_q;
    s2_valid_d = s2_adv ? 1'b1 : (dffcl_out_ready ? 1'b0 : s2_valid_q);
    data_d     = s2_adv ? res : data_q;
    flag_d     = s2_adv ? res_f : flag_q;
    acc_d      = (s2_adv && s1_mode_q == 4'd3) ? acc_s[WIDTH-1:0] :
                 (s2_adv && s1_mode_q == 4'd4) ? a : acc_q;
    cnt_d      = cnt_q + CNT_W'(s2_valid_q && dffcl_out_ready);
  end
  always_ff @(posedge dffcl_clk or negedge dffcl_rst_n) begin
    if (!dffcl_rst_n) begin
      s1_valid_q <= 1'b0;
      s1_mode_q  <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s2_valid_q <= 1'b0;
      data_q     <= '0;
      flag_q     <= 1'b0;
      acc_q      <= '0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_mode_q  <= s1_mode_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s2_valid_q <= s2_valid_d;
      data_q     <= data_d;
      flag_q     <= flag_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
    end
  end
  assign dffcl_in_ready  = !s1_valid_q || s2_adv;
  assign dffcl_out_valid = s2_valid_q;
  assign dffcl_data_out  = data_q;
  assign dffcl_flag_out  = flag_q;
  assign dffcl_op_count  = cnt_q;
endmodule

// File: tb/tb_deep_ff_ctrl_pipe.sv
// tb_deep_ff_ctrl_pipe: directed table and sequence checks for deep_ff_ctrl_pipe
module tb_deep_ff_ctrl_pipe;
  logic        clk = 0, rst_n = 0, in_valid = 0, out_ready = 1;
  logic        in_ready, out_valid, flag;
  logic [3:0]  mode = 0;
  logic [15:0] a = 0, b = 0, dout;
  logic [7:0]  cnt;
  typedef struct {logic [3:0] m; logic [15:0] a; logic [15:0] b; logic [15:0] d; logic f;} vec_t;
  typedef struct {logic [15:0] d; logic f;} exp_t;
  vec_t v[19];
  exp_t q[$];
  int total = 0, bad = 0;
  deep_ff_ctrl_pipe #(.WIDTH(16), .CNT_W(8)) dut (
    .dffcl_clk(clk), .dffcl_rst_n(rst_n), .dffcl_in_valid(in_valid), .dffcl_in_ready(in_ready),
    .dffcl_ctrl_mode(mode), .dffcl_data_in1(a), .dffcl_data_in2(b), .dffcl_out_valid(out_valid),
    .dffcl_out_ready(out_ready), .dffcl_data_out(dout), .dffcl_flag_out(flag), .dffcl_op_count(cnt));
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask
  task automatic push_op(input logic [3:0] m, input logic [15:0] ia, input logic [15:0] ib,
                         input logic [15:0] ed, input logic ef);
    int k = 0;
    mode = m; a = ia; b = ib; in_valid = 1;
    @(negedge clk);
    while (!in_ready && k < 40) begin @(negedge clk); k++; end
    if (!in_ready) chk("accept_timeout", 0, 1);
    else q.push_back('{ed, ef});
    @(posedge clk); #1 in_valid = 0;
  endtask
  task automatic drain();
    int k = 0;
    while (q.size() != 0 && k < 50) begin @(posedge clk); k++; end
    if (q.size() != 0) begin chk("drain_timeout", q.size(), 0); q.delete(); end
    #1;
  endtask
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) chk("unexpected_output", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("data_out", dout, e.d);
        chk("flag_out", flag, e.f);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    v = '{'{4'd0, 16'h0001, 16'h0002, 16'h0003, 1'b0},
          '{4'd0, 16'h8000, 16'h8000, 16'h0000, 1'b1},
          '{4'd1, 16'h0010, 16'h0030, 16'h0020, 1'b1},
          '{4'd1, 16'h0030, 16'h0010, 16'h0020, 1'b0},
          '{4'd1, 16'h1234, 16'h1234, 16'h0000, 1'b0},
          '{4'd5, 16'h8000, 16'h9000, 16'hFFFF, 1'b1},
          '{4'd5, 16'h1000, 16'h2000, 16'h3000, 1'b0},
          '{4'd5, 16'hFFFF, 16'h0000, 16'hFFFF, 1'b0},
          '{4'd2, 16'h2000, 16'h0001, 16'hFFFE, 1'b0},
          '{4'd2, 16'h0000, 16'h1234, 16'h1234, 1'b0},
          '{4'd2, 16'h4004, 16'h0000, 16'h2002, 1'b0},
          '{4'd2, 16'h6001, 16'h0001, 16'hC002, 1'b0},
          '{4'd2, 16'hA000, 16'h0000, 16'hA001, 1'b0},
          '{4'd2, 16'hFFFF, 16'h0000, 16'h0000, 1'b1},
          '{4'd6, 16'h1234, 16'h5678, 16'h1234, 1'b0},
          '{4'd8, 16'h1234, 16'h5678, 16'h5678, 1'b0},
          '{4'd15, 16'h1234, 16'h5678, 16'h1234, 1'b0},
          '{4'd9, 16'h1111, 16'h2222, 16'h2222, 1'b0},
          '{4'd7, 16'hABCD, 16'h0000, 16'hABCD, 1'b0}};
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_data_out", dout, 0);
    chk("rst_flag_out", flag, 0);
    chk("rst_op_count", cnt, 0);
    @(negedge clk) rst_n = 1;
    #1;
    chk("rel_in_ready", in_ready, 1);
    chk("rel_out_valid", out_valid, 0);
    @(posedge clk); #1;
    push_op(4'd0, 16'hFFFF, 16'h0002, 16'h0001, 1'b1);
    chk("lat_not_yet", out_valid, 0);
    @(posedge clk); #1;
    chk("lat_valid", out_valid, 1);
    drain();
    chk("t1_op_count", cnt, 1);
    foreach (v[i]) push_op(v[i].m, v[i].a, v[i].b, v[i].d, v[i].f);
    drain();
    chk("tbl_op_count", cnt, 20);
    push_op(4'd4, 16'h0005, 16'h0000, 16'h0005, 1'b0);
    push_op(4'd3, 16'h0007, 16'h0000, 16'h000C, 1'b0);
    push_op(4'd3, 16'hFFFF, 16'h0000, 16'h000B, 1'b1);
    chk("b2b_valid2", out_valid, 1);
    chk("b2b_data2", dout, 16'h000C);
    @(posedge clk); #1;
    chk("b2b_valid3", out_valid, 1);
    chk("b2b_data3", dout, 16'h000B);
    drain();
    push_op(4'd0, 16'h0001, 16'h0001, 16'h0002, 1'b0);
    push_op(4'd3, 16'h0001, 16'h0000, 16'h000C, 1'b0);
    drain();
    out_ready = 0;
    push_op(4'd0, 16'h0001, 16'h0001, 16'h0002, 1'b0);
    push_op(4'd0, 16'h0003, 16'h0004, 16'h0007, 1'b0);
    for (int s = 0; s < 3; s++) begin
      chk("stall_in_ready", in_ready, 0);
      chk("stall_valid", out_valid, 1);
      chk("stall_data", dout, 16'h0002);
      if (s < 2) begin @(posedge clk); #1; end
    end
    out_ready = 1;
    push_op(4'd5, 16'hFFFF, 16'h0001, 16'hFFFF, 1'b1);
    push_op(4'd1, 16'h0005, 16'h0003, 16'h0002, 1'b0);
    drain();
    chk("t4_op_count", cnt, 29);
    out_ready = 0;
    push_op(4'd0, 16'h0001, 16'h0001, 16'h0002, 1'b0);
    push_op(4'd0, 16'h0002, 16'h0002, 16'h0004, 1'b0);
    rst_n = 0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_op_count", cnt, 0);
    q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    out_ready = 1;
    @(posedge clk); #1;
    push_op(4'd3, 16'h0001, 16'h0000, 16'h0001, 1'b0);
    drain();
    chk("t6_op_count", cnt, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
